writeback_arbiter: RTL and testbench

//  Sole driver of the regfile write port (ctrl_writeEnable/ctrl_writeReg/data_writeReg).

---
 rtl/writeback_arbiter.sv | 174 +++++++++++++++++
 tb/tb_writeback_arbiter.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// ---------------------------------------------------------------------------
// writeback_arbiter
//
// Sole driver of the register-file write port. Merges single-cycle pipeline
// writebacks with results from the long-latency multdiv unit. Multdiv results
// that cannot be written immediately are held in a small in-order FIFO. A
// per-register pending scoreboard tracks multdiv ops whose results have not
// yet reached the register file.
//
// Ports
//   clock             rising-edge clock
//   ctrl_reset        synchronous active-high reset
//   pipe_we/rd/data   pipeline writeback request (always accepted)
//   md_issue/_rd      multdiv op issued this cycle, with its destination
//   md_valid/rd/data  multdiv result, valid/ready handshake
//   md_ready          a multdiv result can be accepted this cycle
//   ctrl_writeEnable  registered regfile write enable
//   ctrl_writeReg     registered regfile write address
//   data_writeReg     registered regfile write data
//   pending           bit r set: multdiv result for r not yet written
//   fifo_count        FIFO occupancy, 0..FIFO_DEPTH
// ---------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                               clock,
    input  logic                               ctrl_reset,
    input  logic                               pipe_we,
    input  logic [ADDR_WIDTH-1:0]              pipe_rd,
    input  logic [DATA_WIDTH-1:0]              pipe_data,
    input  logic                               md_issue,
    input  logic [ADDR_WIDTH-1:0]              md_issue_rd,
    input  logic                               md_valid,
    input  logic [ADDR_WIDTH-1:0]              md_rd,
    input  logic [DATA_WIDTH-1:0]              md_data,
    output logic                               md_ready,
    output logic                               ctrl_writeEnable,
    output logic [ADDR_WIDTH-1:0]              ctrl_writeReg,
    output logic [DATA_WIDTH-1:0]              data_writeReg,
    output logic [(1<<ADDR_WIDTH)-1:0]         pending,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);

    // FIFO storage (no reset needed: only entries below count are ever read)
    logic [ADDR_WIDTH-1:0] fifo_rd_mem   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_mem [FIFO_DEPTH];

    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wreg_q, wreg_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [NUM_REGS-1:0]   pending_q, pending_d;

    logic                  md_accept;
    logic                  md_live;
    logic                  pipe_sel;
    logic                  fifo_nonempty;
    logic                  do_pop;
    logic                  do_bypass;
    logic                  do_push;
    logic                  md_write_sel;

    // Ready depends only on occupancy and reset, never on md_valid, so the
    // multdiv side can't form a combinational loop through this block.
    assign md_ready      = !ctrl_reset && (count_q < CNT_W'(FIFO_DEPTH));
    assign md_accept     = md_valid && md_ready;
    // Results for r0 are accepted but go nowhere.
    assign md_live       = md_accept && (md_rd != '0);
    assign pipe_sel      = pipe_we && (pipe_rd != '0);
    assign fifo_nonempty = (count_q != '0);

    // Priority: pipeline, then FIFO head, then bypass of a fresh result.
    assign do_pop        = !pipe_sel && fifo_nonempty;
    assign do_bypass     = !pipe_sel && !fifo_nonempty && md_live;
    assign do_push       = md_live && !do_bypass;
    assign md_write_sel  = do_pop || do_bypass;

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (pipe_sel) begin
            we_d    = 1'b1;
            wreg_d  = pipe_rd;
            wdata_d = pipe_data;
        end else if (do_pop) begin
            we_d    = 1'b1;
            wreg_d  = fifo_rd_mem[head_q];
            wdata_d = fifo_data_mem[head_q];
        end else if (do_bypass) begin
            we_d    = 1'b1;
            wreg_d  = md_rd;
            wdata_d = md_data;
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (do_pop) begin
            head_d = head_q + PTR_W'(1);
        end
        if (do_push) begin
            tail_d = tail_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Scoreboard: the clear lands on the same edge that registers the
    // md-sourced write, so pending drops as ctrl_writeEnable rises. A new
    // issue to the same register in that cycle keeps the bit set.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            if (gi == 0) begin : g_zero
                assign pending_d[gi] = 1'b0;
            end else begin : g_reg
                logic set_bit;
                logic clr_bit;
                assign set_bit = md_issue && (md_issue_rd == ADDR_WIDTH'(gi));
                assign clr_bit = md_write_sel && (wreg_d == ADDR_WIDTH'(gi));
                assign pending_d[gi] = set_bit || (pending_q[gi] && !clr_bit);
            end
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (do_push) begin
            fifo_rd_mem[tail_q]   <= md_rd;
            fifo_data_mem[tail_q] <= md_data;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            wreg_q    <= '0;
            wdata_q   <= '0;
            pending_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            we_q      <= we_d;
            wreg_q    <= wreg_d;
            wdata_q   <= wdata_d;
            pending_q <= pending_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign pending          = pending_q;
    assign fifo_count       = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// ---------------------------------------------------------------------------
// tb_writeback_arbiter
//
// Directed testbench for writeback_arbiter. Inputs are driven 1 time unit
// after the rising edge; registered outputs are sampled at the same point
// after the following edge, combinational md_ready after a further #1.
// ---------------------------------------------------------------------------
module tb_writeback_arbiter;

    logic        clock;
    logic        ctrl_reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic        md_ready;
    logic        ctrl_writeEnable;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic [31:0] pending;
    logic [1:0]  fifo_count;

    int tests_run    = 0;
    int tests_failed = 0;

    writeback_arbiter #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5),
        .FIFO_DEPTH(2)
    ) dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .pipe_we          (pipe_we),
        .pipe_rd          (pipe_rd),
        .pipe_data        (pipe_data),
        .md_issue         (md_issue),
        .md_issue_rd      (md_issue_rd),
        .md_valid         (md_valid),
        .md_rd            (md_rd),
        .md_data          (md_data),
        .md_ready         (md_ready),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .pending          (pending),
        .fifo_count       (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        pipe_we     = 1'b0;
        pipe_rd     = '0;
        pipe_data   = '0;
        md_issue    = 1'b0;
        md_issue_rd = '0;
        md_valid    = 1'b0;
        md_rd       = '0;
        md_data     = '0;
    endtask

    task automatic test_reset();
        // Build up two queued entries and pending[7] while the pipe hogs the port.
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        md_issue = 1'b1; md_issue_rd = 5'd7;
        md_valid = 1'b1; md_rd = 5'd10; md_data = 32'hA;
        #1;
        tests_run++;
        if (md_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fill_ready0 got %b exp 1", md_ready);
        end
        cyc();
        md_issue = 1'b0;
        pipe_rd = 5'd2; pipe_data = 32'h2;
        md_rd = 5'd11; md_data = 32'hB;
        #1;
        tests_run++;
        if (md_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_fill_ready1 got %b exp 1", md_ready);
        end
        cyc();
        tests_run++;
        if (fifo_count !== 2'd2) begin
            tests_failed++;
            $display("FAIL reset_fill_count got %0d exp 2", fifo_count);
        end
        tests_run++;
        if (pending !== 32'h80) begin
            tests_failed++;
            $display("FAIL reset_fill_pending got %h exp 00000080", pending);
        end
        tests_run++;
        if (md_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_full_ready got %b exp 0", md_ready);
        end
        // Reset mid-operation with pipe and md still active.
        ctrl_reset = 1'b1;
        cyc();
        tests_run++;
        if (fifo_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_count got %0d exp 0", fifo_count);
        end
        tests_run++;
        if (pending !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_pending got %h exp 00000000", pending);
        end
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd0 || data_writeReg !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_port got we=%b reg=%0d data=%h exp we=0 reg=0 data=0",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        ctrl_reset = 1'b0;
        idle();
        #1;
        tests_run++;
        if (md_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready got %b exp 1", md_ready);
        end
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_discard got we=%b count=%0d exp we=0 count=0",
                     ctrl_writeEnable, fifo_count);
        end
    endtask

    task automatic test_pipe_write();
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_data = 32'hDEADBEEF;
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL pipe_write got we=%b reg=%0d data=%h exp we=1 reg=5 data=deadbeef",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        idle();
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || ctrl_writeReg !== 5'd5 || data_writeReg !== 32'hDEADBEEF) begin
            tests_failed++;
            $display("FAIL pipe_idle_hold got we=%b reg=%0d data=%h exp we=0 reg=5 data=deadbeef",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
    endtask

    task automatic test_bypass();
        idle();
        md_issue = 1'b1; md_issue_rd = 5'd7;
        cyc();
        tests_run++;
        if (pending !== 32'h80) begin
            tests_failed++;
            $display("FAIL bypass_issue_pending got %h exp 00000080", pending);
        end
        idle();
        cyc();
        cyc();
        tests_run++;
        if (pending !== 32'h80 || ctrl_writeEnable !== 1'b0) begin
            tests_failed++;
            $display("FAIL bypass_wait got pending=%h we=%b exp pending=00000080 we=0",
                     pending, ctrl_writeEnable);
        end
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h12345678;
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || data_writeReg !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL bypass_write got we=%b reg=%0d data=%h exp we=1 reg=7 data=12345678",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (pending !== 32'h0 || fifo_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL bypass_state got pending=%h count=%0d exp pending=00000000 count=0",
                     pending, fifo_count);
        end
        idle();
        cyc();
    endtask

    task automatic test_pipe_and_md();
        idle();
        md_issue = 1'b1; md_issue_rd = 5'd9;
        cyc();
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd3; pipe_data = 32'h11;
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h22;
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd3 || data_writeReg !== 32'h11) begin
            tests_failed++;
            $display("FAIL coll_first got we=%b reg=%0d data=%h exp we=1 reg=3 data=00000011",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (fifo_count !== 2'd1 || pending !== 32'h200) begin
            tests_failed++;
            $display("FAIL coll_queued got count=%0d pending=%h exp count=1 pending=00000200",
                     fifo_count, pending);
        end
        idle();
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd9 || data_writeReg !== 32'h22) begin
            tests_failed++;
            $display("FAIL coll_second got we=%b reg=%0d data=%h exp we=1 reg=9 data=00000022",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (fifo_count !== 2'd0 || pending !== 32'h0) begin
            tests_failed++;
            $display("FAIL coll_drained got count=%0d pending=%h exp count=0 pending=00000000",
                     fifo_count, pending);
        end
        cyc();
    endtask

    task automatic test_back_to_back();
        // Per cycle: pipe for 4 cycles; md presents A, B, then C held until taken.
        logic [31:0] p_we   [7] = '{1, 1, 1, 1, 0, 0, 0};
        logic [31:0] p_rd   [7] = '{1, 2, 3, 4, 0, 0, 0};
        logic [31:0] m_v    [7] = '{1, 1, 1, 1, 1, 1, 0};
        logic [31:0] m_rd   [7] = '{12, 13, 14, 14, 14, 14, 0};
        logic [31:0] m_dat  [7] = '{32'hA0, 32'hB0, 32'hC0, 32'hC0, 32'hC0, 32'hC0, 0};
        logic [31:0] e_rdy  [7] = '{1, 1, 0, 0, 0, 1, 1};
        logic [31:0] e_reg  [7] = '{1, 2, 3, 4, 12, 13, 14};
        logic [31:0] e_dat  [7] = '{32'h101, 32'h102, 32'h103, 32'h104, 32'hA0, 32'hB0, 32'hC0};
        logic [31:0] e_cnt  [7] = '{1, 2, 2, 2, 1, 1, 0};
        for (int i = 0; i < 7; i++) begin
            idle();
            pipe_we   = p_we[i][0];
            pipe_rd   = p_rd[i][4:0];
            pipe_data = 32'h100 + p_rd[i];
            md_valid  = m_v[i][0];
            md_rd     = m_rd[i][4:0];
            md_data   = m_dat[i];
            #1;
            tests_run++;
            if (md_ready !== e_rdy[i][0]) begin
                tests_failed++;
                $display("FAIL b2b_ready[%0d] got %b exp %b", i, md_ready, e_rdy[i][0]);
            end
            cyc();
            tests_run++;
            if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== e_reg[i][4:0] ||
                data_writeReg !== e_dat[i] || fifo_count !== e_cnt[i][1:0]) begin
                tests_failed++;
                $display("FAIL b2b_write[%0d] got we=%b reg=%0d data=%h count=%0d exp we=1 reg=%0d data=%h count=%0d",
                         i, ctrl_writeEnable, ctrl_writeReg, data_writeReg, fifo_count,
                         e_reg[i], e_dat[i], e_cnt[i]);
            end
        end
        idle();
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0) begin
            tests_failed++;
            $display("FAIL b2b_end got we=%b count=%0d exp we=0 count=0",
                     ctrl_writeEnable, fifo_count);
        end
    endtask

    task automatic test_zero_reg();
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd1; pipe_data = 32'h1;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h44;
        cyc();
        tests_run++;
        if (fifo_count !== 2'd1) begin
            tests_failed++;
            $display("FAIL zero_setup_count got %0d exp 1", fifo_count);
        end
        // r0 pipe write frees the port; r0 issue and r0 result do nothing.
        idle();
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_data = 32'hFFFF;
        md_issue = 1'b1; md_issue_rd = 5'd0;
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h99;
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd4 || data_writeReg !== 32'h44) begin
            tests_failed++;
            $display("FAIL zero_pipe_pop got we=%b reg=%0d data=%h exp we=1 reg=4 data=00000044",
                     ctrl_writeEnable, ctrl_writeReg, data_writeReg);
        end
        tests_run++;
        if (fifo_count !== 2'd0 || pending !== 32'h0) begin
            tests_failed++;
            $display("FAIL zero_state got count=%0d pending=%h exp count=0 pending=00000000",
                     fifo_count, pending);
        end
        idle();
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h99;
        #1;
        tests_run++;
        if (md_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_md_ready got %b exp 1", md_ready);
        end
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0 || ctrl_writeReg !== 5'd4) begin
            tests_failed++;
            $display("FAIL zero_md_discard got we=%b count=%0d reg=%0d exp we=0 count=0 reg=4",
                     ctrl_writeEnable, fifo_count, ctrl_writeReg);
        end
        idle();
        cyc();
    endtask

    task automatic test_set_wins();
        idle();
        md_issue = 1'b1; md_issue_rd = 5'd7;
        cyc();
        // Result for r7 written while a new op to r7 issues: bit must stay set.
        idle();
        md_issue = 1'b1; md_issue_rd = 5'd7;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77;
        cyc();
        tests_run++;
        if (ctrl_writeEnable !== 1'b1 || ctrl_writeReg !== 5'd7 || pending !== 32'h80) begin
            tests_failed++;
            $display("FAIL setwins got we=%b reg=%0d pending=%h exp we=1 reg=7 pending=00000080",
                     ctrl_writeEnable, ctrl_writeReg, pending);
        end
        idle();
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h78;
        cyc();
        tests_run++;
        if (pending !== 32'h0 || data_writeReg !== 32'h78) begin
            tests_failed++;
            $display("FAIL setwins_clear got pending=%h data=%h exp pending=00000000 data=00000078",
                     pending, data_writeReg);
        end
        idle();
        cyc();
    endtask

    initial begin
        idle();
        ctrl_reset = 1'b1;
        cyc();
        cyc();
        #1;
        tests_run++;
        if (md_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL init_reset_ready got %b exp 0", md_ready);
        end
        tests_run++;
        if (ctrl_writeEnable !== 1'b0 || fifo_count !== 2'd0 || pending !== 32'h0) begin
            tests_failed++;
            $display("FAIL init_reset_state got we=%b count=%0d pending=%h exp we=0 count=0 pending=00000000",
                     ctrl_writeEnable, fifo_count, pending);
        end
        ctrl_reset = 1'b0;
        cyc();

        test_reset();
        test_pipe_write();
        test_bypass();
        test_pipe_and_md();
        test_back_to_back();
        test_zero_reg();
        test_set_wins();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
